// File: rtl/erx_distrib_pkg.sv
// Emesh field offsets and receive-channel classification shared by the elink tx/rx blocks.
package erx_distrib_pkg;

    localparam int         EMESH_WRITE_BIT = 0;
    localparam int         EMESH_DST_LSB   = 8;
    localparam int         EMESH_DST_MSB   = 39;
    localparam int         EMESH_CHIP_W    = 12;
    localparam int         EMESH_REGION_W  = 4;
    localparam logic [3:0] EMESH_RR_REGION = 4'hE;

    localparam int NUM_CHAN = 3;

    typedef enum logic [1:0] {
        CH_WR = 2'd0,
        CH_RD = 2'd1,
        CH_RR = 2'd2
    } chan_e;

    // A write aimed at our own chip inside the read-response region is a returning read.
    function automatic chan_e emesh_classify(
        input logic                      write,
        input logic [EMESH_CHIP_W-1:0]   chip,
        input logic [EMESH_REGION_W-1:0] region,
        input logic [EMESH_CHIP_W-1:0]   id,
        input logic [EMESH_REGION_W-1:0] rr_region
    );
        if (!write) begin
            return CH_RD;
        end
        if ((chip == id) && (region == rr_region)) begin
            return CH_RR;
        end
        return CH_WR;
    endfunction

endpackage

// File: rtl/erx_chan_fifo.sv
// Single-clock per-channel packet buffer with access/wait handshakes on both sides.
module erx_chan_fifo #(
    parameter int PW    = 104,
    parameter int DEPTH = 4
) (
    input  logic          i_clk,
    input  logic          i_nreset,
    input  logic          i_in_access,
    input  logic [PW-1:0] i_in_packet,
    output logic          o_in_wait,
    output logic          o_out_access,
    output logic [PW-1:0] o_out_packet,
    input  logic          i_out_wait,
    output logic          o_full
);

    localparam int            PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [PW-1:0]    r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_push;
    logic             w_pop;

    // The occupancy count, not the pointers, separates full from empty when they meet.
    assign o_full       = (r_count == FULL_CNT);
    assign o_in_wait    = o_full;
    assign o_out_access = (r_count != '0);
    assign o_out_packet = r_mem[r_rd_ptr];

    assign w_push = i_in_access & ~o_full;
    assign w_pop  = o_out_access & ~i_out_wait;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (!i_nreset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage has no reset; stale entries are invisible because access follows the count.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_in_packet;
        end
    end

endmodule

// File: rtl/erx_distrib.sv
// Elink receive distributor: steers inbound emesh packets into write, read and read-response channels.
module erx_distrib
    import erx_distrib_pkg::*;
#(
    parameter int          PW        = 104,
    parameter int          AW        = 32,
    parameter logic [11:0] ID        = 12'h000,
    parameter logic [3:0]  RR_REGION = EMESH_RR_REGION,
    parameter int          DEPTH     = 4
) (
    input  logic          sys_clk,
    input  logic          sys_nreset,
    input  logic          rx_access,
    input  logic [PW-1:0] rx_packet,
    output logic          rx_wait,
    output logic          rxwr_access,
    output logic [PW-1:0] rxwr_packet,
    input  logic          rxwr_wait,
    output logic [7:0]    rxwr_count,
    output logic          rxrd_access,
    output logic [PW-1:0] rxrd_packet,
    input  logic          rxrd_wait,
    output logic [7:0]    rxrd_count,
    output logic          rxrr_access,
    output logic [PW-1:0] rxrr_packet,
    input  logic          rxrr_wait,
    output logic [7:0]    rxrr_count
);

    localparam int CHIP_MSB   = EMESH_DST_LSB + AW - 1;
    localparam int REGION_MSB = CHIP_MSB - EMESH_CHIP_W;

    chan_e               w_class;
    logic                w_accept;
    logic [NUM_CHAN-1:0] w_push;
    logic [NUM_CHAN-1:0] w_full;
    logic [NUM_CHAN-1:0] w_in_wait;
    logic [NUM_CHAN-1:0] w_out_access;
    logic [NUM_CHAN-1:0] w_out_wait;
    logic [PW-1:0]       w_out_packet [NUM_CHAN];
    logic [7:0]          r_count [NUM_CHAN];

    assign w_class = emesh_classify(rx_packet[EMESH_WRITE_BIT],
                                    rx_packet[CHIP_MSB -: EMESH_CHIP_W],
                                    rx_packet[REGION_MSB -: EMESH_REGION_W],
                                    ID, RR_REGION);

    // Built from registered occupancy only, so a same-cycle pop never reopens the link early.
    assign rx_wait  = |w_full;
    assign w_accept = rx_access & ~rx_wait;

    // NOTE: default every always_comb output first so no path leaves a latch behind.
    always_comb begin
        w_push = '0;
        for (int i = 0; i < NUM_CHAN; i++) begin
            w_push[i] = w_accept && (int'(w_class) == i) && !w_in_wait[i];
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_nreset) begin
            for (int i = 0; i < NUM_CHAN; i++) begin
                r_count[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CHAN; i++) begin
                if (w_push[i] && (r_count[i] != 8'hFF)) begin
                    r_count[i] <= r_count[i] + 8'd1;
                end
            end
        end
    end

    assign w_out_wait[int'(CH_WR)] = rxwr_wait;
    assign w_out_wait[int'(CH_RD)] = rxrd_wait;
    assign w_out_wait[int'(CH_RR)] = rxrr_wait;

    for (genvar g = 0; g < NUM_CHAN; g++) begin : g_chan
        erx_chan_fifo #(
            .PW    (PW),
            .DEPTH (DEPTH)
        ) u_fifo (
            .i_clk        (sys_clk),
            .i_nreset     (sys_nreset),
            .i_in_access  (w_push[g]),
            .i_in_packet  (rx_packet),
            .o_in_wait    (w_in_wait[g]),
            .o_out_access (w_out_access[g]),
            .o_out_packet (w_out_packet[g]),
            .i_out_wait   (w_out_wait[g]),
            .o_full       (w_full[g])
        );
    end

    assign rxwr_access = w_out_access[int'(CH_WR)];
    assign rxwr_packet = w_out_packet[int'(CH_WR)];
    assign rxwr_count  = r_count[int'(CH_WR)];
    assign rxrd_access = w_out_access[int'(CH_RD)];
    assign rxrd_packet = w_out_packet[int'(CH_RD)];
    assign rxrd_count  = r_count[int'(CH_RD)];
    assign rxrr_access = w_out_access[int'(CH_RR)];
    assign rxrr_packet = w_out_packet[int'(CH_RR)];
    assign rxrr_count  = r_count[int'(CH_RR)];

endmodule

// File: tb/tb_erx_distrib.sv
// Directed bench for erx_distrib: reset, classification, backpressure, push/pop overlap, saturation.
module tb_erx_distrib;

    localparam int PW = 104;

    logic          sys_clk;
    logic          sys_nreset;
    logic          rx_access;
    logic [PW-1:0] rx_packet;
    logic          rx_wait;
    logic          rxwr_access, rxrd_access, rxrr_access;
    logic [PW-1:0] rxwr_packet, rxrd_packet, rxrr_packet;
    logic          rxwr_wait, rxrd_wait, rxrr_wait;
    logic [7:0]    rxwr_count, rxrd_count, rxrr_count;

    int n_checks = 0;
    int n_pass   = 0;

    erx_distrib #(
        .PW        (PW),
        .AW        (32),
        .ID        (12'h810),
        .RR_REGION (4'hE),
        .DEPTH     (4)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_nreset  (sys_nreset),
        .rx_access   (rx_access),
        .rx_packet   (rx_packet),
        .rx_wait     (rx_wait),
        .rxwr_access (rxwr_access),
        .rxwr_packet (rxwr_packet),
        .rxwr_wait   (rxwr_wait),
        .rxwr_count  (rxwr_count),
        .rxrd_access (rxrd_access),
        .rxrd_packet (rxrd_packet),
        .rxrd_wait   (rxrd_wait),
        .rxrd_count  (rxrd_count),
        .rxrr_access (rxrr_access),
        .rxrr_packet (rxrr_packet),
        .rxrr_wait   (rxrr_wait),
        .rxrr_count  (rxrr_count)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    function automatic logic [PW-1:0] mk(input logic wr, input logic [31:0] dst, input logic [15:0] tag);
        logic [PW-1:0] p;
        p         = '0;
        p[0]      = wr;
        p[39:8]   = dst;
        p[103:88] = tag;
        return p;
    endfunction

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    endtask

    task automatic check_byte(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    endtask

    task automatic check_pkt(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %026h expected %026h", tag, obs, exp);
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the rising edge.
    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check_bit({tag, "_wr_access"}, rxwr_access, 1'b0);
        check_bit({tag, "_rd_access"}, rxrd_access, 1'b0);
        check_bit({tag, "_rr_access"}, rxrr_access, 1'b0);
        check_bit({tag, "_rx_wait"}, rx_wait, 1'b0);
        check_byte({tag, "_wr_count"}, rxwr_count, 8'h00);
        check_byte({tag, "_rd_count"}, rxrd_count, 8'h00);
        check_byte({tag, "_rr_count"}, rxrr_count, 8'h00);
    endtask

    task automatic do_reset();
        rx_access  = 1'b0;
        sys_nreset = 1'b0;
        repeat (3) step();
        sys_nreset = 1'b1;
    endtask

    initial begin
        sys_nreset = 1'b0;
        rx_access  = 1'b0;
        rx_packet  = '0;
        rxwr_wait  = 1'b0;
        rxrd_wait  = 1'b0;
        rxrr_wait  = 1'b0;

        // Power-on reset
        do_reset();
        check_idle("por");

        // Classification: RD, RR, WR back to back, each visible one cycle after acceptance
        rx_access = 1'b1;
        rx_packet = mk(1'b0, 32'h1234_5678, 16'h0001);
        step();
        check_bit("cls_rd_access", rxrd_access, 1'b1);
        check_pkt("cls_rd_packet", rxrd_packet, mk(1'b0, 32'h1234_5678, 16'h0001));
        check_bit("cls_rd_no_wr", rxwr_access, 1'b0);
        check_bit("cls_rd_no_rr", rxrr_access, 1'b0);
        rx_packet = mk(1'b1, 32'h810E_0000, 16'h0002);
        step();
        check_bit("cls_rr_access", rxrr_access, 1'b1);
        check_pkt("cls_rr_packet", rxrr_packet, mk(1'b1, 32'h810E_0000, 16'h0002));
        check_bit("cls_rr_rd_gone", rxrd_access, 1'b0);
        check_bit("cls_rr_no_wr", rxwr_access, 1'b0);
        rx_packet = mk(1'b1, 32'h8100_0000, 16'h0003);
        step();
        check_bit("cls_wr_access", rxwr_access, 1'b1);
        check_pkt("cls_wr_packet", rxwr_packet, mk(1'b1, 32'h8100_0000, 16'h0003));
        check_bit("cls_wr_rr_gone", rxrr_access, 1'b0);
        check_bit("cls_wr_no_rd", rxrd_access, 1'b0);
        rx_access = 1'b0;
        step();
        check_bit("cls_end_wr", rxwr_access, 1'b0);
        check_byte("cls_wr_count", rxwr_count, 8'd1);
        check_byte("cls_rd_count", rxrd_count, 8'd1);
        check_byte("cls_rr_count", rxrr_count, 8'd1);

        // Backpressure: fill the WR buffer while it is stalled
        rxwr_wait = 1'b1;
        rx_access = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_bit("bp_open_before_accept", rx_wait, 1'b0);
            rx_packet = mk(1'b1, 32'h0000_1000, 16'h0010 + 16'(i));
            step();
        end
        check_bit("bp_wait_after_4th", rx_wait, 1'b1);
        rx_packet = mk(1'b1, 32'h0000_1000, 16'h0014);
        step();
        step();
        check_bit("bp_wait_held", rx_wait, 1'b1);
        check_byte("bp_5th_not_counted", rxwr_count, 8'd5);
        check_pkt("bp_head_stable", rxwr_packet, mk(1'b1, 32'h0000_1000, 16'h0010));
        rxwr_wait = 1'b0;
        step();
        check_bit("bp_wait_released", rx_wait, 1'b0);
        check_pkt("bp_out_1", rxwr_packet, mk(1'b1, 32'h0000_1000, 16'h0011));
        step();
        rx_access = 1'b0;
        check_pkt("bp_out_2", rxwr_packet, mk(1'b1, 32'h0000_1000, 16'h0012));
        step();
        check_pkt("bp_out_3", rxwr_packet, mk(1'b1, 32'h0000_1000, 16'h0013));
        step();
        check_bit("bp_out_4_access", rxwr_access, 1'b1);
        check_pkt("bp_out_4", rxwr_packet, mk(1'b1, 32'h0000_1000, 16'h0014));
        step();
        check_bit("bp_drained", rxwr_access, 1'b0);
        check_byte("bp_wr_count", rxwr_count, 8'd6);

        // Simultaneous push and pop on a single-entry RD channel
        rxrd_wait = 1'b1;
        rx_access = 1'b1;
        rx_packet = mk(1'b0, 32'h0000_2000, 16'h0020);
        step();
        check_pkt("sim_head_0", rxrd_packet, mk(1'b0, 32'h0000_2000, 16'h0020));
        rx_packet = mk(1'b0, 32'h0000_2000, 16'h0021);
        rxrd_wait = 1'b0;
        step();
        rx_access = 1'b0;
        rxrd_wait = 1'b1;
        check_bit("sim_access", rxrd_access, 1'b1);
        check_pkt("sim_head_1", rxrd_packet, mk(1'b0, 32'h0000_2000, 16'h0021));
        step();
        check_pkt("sim_hold", rxrd_packet, mk(1'b0, 32'h0000_2000, 16'h0021));
        rxrd_wait = 1'b0;
        step();
        check_bit("sim_one_entry", rxrd_access, 1'b0);
        check_byte("sim_rd_count", rxrd_count, 8'd3);

        // Reset mid-stream with three RR packets buffered
        rxrr_wait = 1'b1;
        rx_access = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rx_packet = mk(1'b1, 32'h810E_0040, 16'h0030 + 16'(i));
            step();
        end
        rx_access = 1'b0;
        check_bit("mid_rr_buffered", rxrr_access, 1'b1);
        do_reset();
        rxrr_wait = 1'b0;
        check_idle("mid_rst");
        step();
        step();
        check_bit("mid_rr_quiet", rxrr_access, 1'b0);
        rx_access = 1'b1;
        rx_packet = mk(1'b1, 32'h810E_0080, 16'h0040);
        step();
        rx_access = 1'b0;
        check_bit("mid_new_rr", rxrr_access, 1'b1);
        check_pkt("mid_new_rr_pkt", rxrr_packet, mk(1'b1, 32'h810E_0080, 16'h0040));

        // Counter saturation on the RD channel
        do_reset();
        rx_access = 1'b1;
        for (int i = 0; i < 300; i++) begin
            rx_packet = mk(1'b0, 32'h0000_3000, 16'(i));
            step();
        end
        rx_access = 1'b0;
        check_byte("sat_rd_count", rxrd_count, 8'hFF);
        check_byte("sat_wr_count", rxwr_count, 8'h00);
        check_byte("sat_rr_count", rxrr_count, 8'h00);
        check_pkt("sat_last_pkt", rxrd_packet, mk(1'b0, 32'h0000_3000, 16'd299));
        step();
        check_bit("sat_drained", rxrd_access, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
